// File: rtl/riscv_pkg.sv
// Shared types for the load/store unit: access size encodings, FSM states, byte-mask helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package riscv_pkg;

    // Access size as carried in the load/store funct3 field
    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_D  = 3'd3,
        MEM_BU = 3'd4,
        MEM_HU = 3'd5,
        MEM_WU = 3'd6
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } lsu_state_e;

    // Byte-enable mask of an access at lane 0; signedness bit is irrelevant here
    function automatic logic [7:0] size_mask(input logic [2:0] size);
        case (size[1:0])
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Lane steering: misalignment check, store strobe/data shift, load extract and sign/zero extend.
// Latency: combinational.
// Backpressure: none, pure datapath.
module riscv_lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  req_size,
    input  logic [2:0]  req_off,
    input  logic [63:0] req_wdata,
    output logic        misaligned,
    output logic [7:0]  lane_strb,
    output logic [63:0] lane_wdata,
    input  logic [2:0]  ld_size,
    input  logic [2:0]  ld_off,
    input  logic [63:0] ld_beat,
    output logic [63:0] ld_data
);

    logic [63:0] ld_shifted;

    // Natural alignment: the low address bits covered by the access width must be zero
    always_comb begin
        misaligned = 1'b0;
        case (req_size[1:0])
            2'd1:    misaligned = req_off[0];
            2'd2:    misaligned = |req_off[1:0];
            2'd3:    misaligned = |req_off;
            default: misaligned = 1'b0;
        endcase
    end

    assign lane_strb  = size_mask(req_size) << req_off;
    assign lane_wdata = req_wdata << {req_off, 3'b000};
    assign ld_shifted = ld_beat >> {ld_off, 3'b000};

    // Bring the addressed bytes down to bit 0, then extend according to the size code
    always_comb begin
        ld_data = ld_shifted;
        case (ld_size)
            MEM_B:   ld_data = {{56{ld_shifted[7]}},  ld_shifted[7:0]};
            MEM_H:   ld_data = {{48{ld_shifted[15]}}, ld_shifted[15:0]};
            MEM_W:   ld_data = {{32{ld_shifted[31]}}, ld_shifted[31:0]};
            MEM_BU:  ld_data = {56'd0, ld_shifted[7:0]};
            MEM_HU:  ld_data = {48'd0, ld_shifted[15:0]};
            MEM_WU:  ld_data = {32'd0, ld_shifted[31:0]};
            default: ld_data = ld_shifted;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one core dmem access becomes one aligned 8-byte bus beat with strobes.
// Latency: request issued the cycle after acceptance; core released one cycle after the bus response.
// Backpressure: core_stall holds the pipeline; bus_req_valid held with stable payload until bus_req_ready.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_re,
    input  logic        core_we,
    input  logic [63:0] core_addr,
    input  logic [63:0] core_wdata,
    input  logic [2:0]  core_size,
    output logic [63:0] core_rdata,
    output logic        core_stall,
    output logic        core_fault,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [63:0] bus_addr,
    output logic        bus_we,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [63:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e  state;
    logic [CW-1:0] wait_cnt;
    logic [2:0]  lat_size;
    logic [2:0]  lat_off;

    logic        req;
    logic        illegal;
    logic        timeout;
    logic        misaligned;
    logic [7:0]  lane_strb;
    logic [63:0] lane_wdata;
    logic [63:0] ld_data;

    riscv_lsu_align u_align (
        .req_size   (core_size),
        .req_off    (core_addr[2:0]),
        .req_wdata  (core_wdata),
        .misaligned (misaligned),
        .lane_strb  (lane_strb),
        .lane_wdata (lane_wdata),
        .ld_size    (lat_size),
        .ld_off     (lat_off),
        .ld_beat    (bus_rdata),
        .ld_data    (ld_data)
    );

    assign req     = core_re | core_we;
    // Size 7 is not a valid funct3; unsigned variants only exist for loads
    assign illegal = (core_re & core_we) | (core_we & core_size[2]) | (core_size == 3'd7) | misaligned;
    // A response arriving on the expiry cycle takes precedence over the timeout
    assign timeout = (state == ST_WAIT_RSP) && !bus_rsp_valid && (wait_cnt == CW'(TIMEOUT_CYCLES));

    // Faults release the core in the same cycle so it can trap instead of waiting
    assign core_fault    = rst_n && (((state == ST_IDLE) && req && illegal) || timeout);
    assign core_stall    = rst_n && (((state == ST_IDLE) && req && !illegal) ||
                                     (state == ST_REQ) ||
                                     ((state == ST_WAIT_RSP) && !timeout));
    assign bus_req_valid = (state == ST_REQ);

    // Access FSM: latch the request, hold it on the bus, then wait for the single response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            lat_size   <= 3'd0;
            lat_off    <= 3'd0;
            bus_addr   <= 64'd0;
            bus_we     <= 1'b0;
            bus_wdata  <= 64'd0;
            bus_wstrb  <= 8'd0;
            core_rdata <= 64'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req && !illegal) begin
                        state     <= ST_REQ;
                        bus_addr  <= {core_addr[63:3], 3'b000};
                        bus_we    <= core_we;
                        bus_wdata <= lane_wdata;
                        bus_wstrb <= core_we ? lane_strb : 8'h00;
                        lat_size  <= core_size;
                        lat_off   <= core_addr[2:0];
                    end
                end
                ST_REQ: begin
                    if (bus_req_ready) begin
                        state    <= ST_WAIT_RSP;
                        wait_cnt <= '0;
                    end
                end
                ST_WAIT_RSP: begin
                    if (bus_rsp_valid) begin
                        state <= ST_DONE;
                        if (!bus_we) begin
                            core_rdata <= ld_data;
                        end
                    end else if (wait_cnt == CW'(TIMEOUT_CYCLES)) begin
                        state      <= ST_IDLE;
                        core_rdata <= 64'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    // DONE: the core advances this cycle; its request lines are not sampled
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
